// File: rtl/alu_ctrl.sv
// Sequencing controller for an iterative external ALU: decodes RV32 OP/OP-IMM/BRANCH
// requests, re-issues partial shift/shadd results until the ALU is ready, holds the response.
module alu_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_instr,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_taken,
    output logic        rsp_illegal,
    input  logic        flush,
    output logic        alu_start,
    output logic [31:0] alu_src_a,
    output logic [31:0] alu_src_b,
    output logic [2:0]  alu_f3,
    output logic        alu_arith_bit,
    output logic        alu_shadd,
    output logic        alu_branch,
    input  logic [31:0] alu_result,
    input  logic [4:0]  alu_shamt,
    input  logic        alu_ready
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [6:0] OPC_OP  = 7'b0110011;
    localparam logic [6:0] OPC_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BR  = 7'b1100011;

    // Longest legitimate EXEC (right shift by 31) is 12 cycles; capture on the 12th regardless.
    localparam logic [3:0] EXEC_LAST = 4'd11;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] src_a_q, src_a_d, src_b_q, src_b_d;
    logic [2:0]  f3_q, f3_d;
    logic        arith_q, arith_d, shadd_q, shadd_d, branch_q, branch_d, shift_q, shift_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_taken_q, rsp_taken_d, rsp_illegal_q, rsp_illegal_d;

    logic [6:0]  dec_opc, dec_f7;
    logic [2:0]  dec_f3;
    logic        dec_legal, dec_shift, dec_shadd, dec_branch, dec_arith;
    logic [31:0] dec_src_b;
    logic        in_exec;

    assign dec_opc = req_instr[6:0];
    assign dec_f3  = req_instr[14:12];
    assign dec_f7  = req_instr[31:25];

    always_comb begin
        dec_legal  = 1'b0;
        dec_shift  = 1'b0;
        dec_shadd  = 1'b0;
        dec_branch = 1'b0;
        dec_arith  = 1'b0;
        dec_src_b  = req_rs2;
        case (dec_opc)
            OPC_OP: begin
                dec_shift = (dec_f3 == 3'b001) || (dec_f3 == 3'b101);
                dec_arith = req_instr[30] && ((dec_f3 == 3'b000) || (dec_f3 == 3'b101));
                case (dec_f7)
                    7'b0000000: dec_legal = 1'b1;
                    7'b0100000: dec_legal = (dec_f3 == 3'b000) || (dec_f3 == 3'b101);
                    7'b0010000: begin
                        dec_legal = (dec_f3 == 3'b010) || (dec_f3 == 3'b100) ||
                                    (dec_f3 == 3'b110);
                        dec_shadd = 1'b1;
                        dec_shift = 1'b0;
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            OPC_IMM: begin
                dec_legal = 1'b1;
                dec_shift = (dec_f3 == 3'b001) || (dec_f3 == 3'b101);
                dec_arith = req_instr[30] && (dec_f3 == 3'b101);
                dec_src_b = dec_shift ? {27'b0, req_instr[24:20]}
                                      : {{20{req_instr[31]}}, req_instr[31:20]};
            end
            OPC_BR: begin
                dec_legal  = (dec_f3 != 3'b010) && (dec_f3 != 3'b011);
                dec_branch = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        src_a_d       = src_a_q;
        src_b_d       = src_b_q;
        f3_d          = f3_q;
        arith_d       = arith_q;
        shadd_d       = shadd_q;
        branch_d      = branch_q;
        shift_d       = shift_q;
        rsp_data_d    = rsp_data_q;
        rsp_taken_d   = rsp_taken_q;
        rsp_illegal_d = rsp_illegal_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (dec_legal) begin
                        state_d  = EXEC;
                        cnt_d    = 4'd0;
                        src_a_d  = req_rs1;
                        src_b_d  = dec_src_b;
                        f3_d     = dec_f3;
                        arith_d  = dec_arith;
                        shadd_d  = dec_shadd;
                        branch_d = dec_branch;
                        shift_d  = dec_shift;
                    end else begin
                        state_d       = RESP;
                        rsp_data_d    = 32'd0;
                        rsp_taken_d   = 1'b0;
                        rsp_illegal_d = 1'b1;
                    end
                end
            end
            EXEC: begin
                cnt_d = cnt_q + 4'd1;
                if (alu_ready || (cnt_q == EXEC_LAST)) begin
                    state_d       = RESP;
                    rsp_data_d    = alu_result;
                    rsp_taken_d   = branch_q & alu_result[0];
                    rsp_illegal_d = 1'b0;
                end else if (shift_q) begin
                    src_a_d = alu_result;
                    src_b_d = {27'b0, alu_shamt};
                end else if (shadd_q) begin
                    src_a_d = alu_result;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d       = IDLE;
                    rsp_data_d    = 32'd0;
                    rsp_taken_d   = 1'b0;
                    rsp_illegal_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d       = IDLE;
            rsp_data_d    = 32'd0;
            rsp_taken_d   = 1'b0;
            rsp_illegal_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            src_a_q       <= 32'd0;
            src_b_q       <= 32'd0;
            f3_q          <= 3'd0;
            arith_q       <= 1'b0;
            shadd_q       <= 1'b0;
            branch_q      <= 1'b0;
            shift_q       <= 1'b0;
            rsp_data_q    <= 32'd0;
            rsp_taken_q   <= 1'b0;
            rsp_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            src_a_q       <= src_a_d;
            src_b_q       <= src_b_d;
            f3_q          <= f3_d;
            arith_q       <= arith_d;
            shadd_q       <= shadd_d;
            branch_q      <= branch_d;
            shift_q       <= shift_d;
            rsp_data_q    <= rsp_data_d;
            rsp_taken_q   <= rsp_taken_d;
            rsp_illegal_q <= rsp_illegal_d;
        end
    end

    assign in_exec       = (state_q == EXEC);
    assign req_ready     = rst_n && (state_q == IDLE);
    assign rsp_valid     = (state_q == RESP) && !flush;
    assign rsp_data      = rsp_data_q;
    assign rsp_taken     = rsp_taken_q;
    assign rsp_illegal   = rsp_illegal_q;
    assign alu_start     = in_exec && (cnt_q == 4'd0) && !flush;
    assign alu_src_a     = in_exec ? src_a_q : 32'd0;
    assign alu_src_b     = in_exec ? src_b_q : 32'd0;
    assign alu_f3        = in_exec ? f3_q : 3'd0;
    assign alu_arith_bit = in_exec && arith_q;
    assign alu_shadd     = in_exec && shadd_q;
    assign alu_branch    = in_exec && branch_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: reference iterative ALU, directed requests, queue-based response checker.
module tb_alu_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [31:0] req_instr, req_rs1, req_rs2;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_taken, rsp_illegal, flush;
    logic        alu_start;
    logic [31:0] alu_src_a, alu_src_b;
    logic [2:0]  alu_f3;
    logic        alu_arith_bit, alu_shadd, alu_branch;
    logic [31:0] alu_result;
    logic [4:0]  alu_shamt;
    logic        alu_ready;

    alu_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_instr(req_instr),
        .req_rs1(req_rs1), .req_rs2(req_rs2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_taken(rsp_taken), .rsp_illegal(rsp_illegal), .flush(flush),
        .alu_start(alu_start), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_f3(alu_f3), .alu_arith_bit(alu_arith_bit), .alu_shadd(alu_shadd),
        .alu_branch(alu_branch), .alu_result(alu_result), .alu_shamt(alu_shamt),
        .alu_ready(alu_ready)
    );

    always #5 clk = ~clk;

    // Reference ALU: shifts move at most 3 bits per cycle; shadd shifts on start, adds next.
    logic       m_cond;
    logic [4:0] m_step;
    always_comb begin
        alu_result = 32'd0;
        alu_shamt  = 5'd0;
        alu_ready  = 1'b1;
        m_cond     = 1'b0;
        m_step     = 5'd0;
        if (alu_shadd) begin
            if (alu_start) begin
                alu_result = alu_src_a << alu_f3[2:1];
                alu_ready  = 1'b0;
            end else begin
                alu_result = alu_src_a + alu_src_b;
            end
        end else if (alu_branch) begin
            case (alu_f3)
                3'b000:  m_cond = (alu_src_a == alu_src_b);
                3'b001:  m_cond = (alu_src_a != alu_src_b);
                3'b100:  m_cond = ($signed(alu_src_a) < $signed(alu_src_b));
                3'b101:  m_cond = ($signed(alu_src_a) >= $signed(alu_src_b));
                3'b110:  m_cond = (alu_src_a < alu_src_b);
                3'b111:  m_cond = (alu_src_a >= alu_src_b);
                default: m_cond = 1'b0;
            endcase
            alu_result = {31'b0, m_cond};
        end else begin
            case (alu_f3)
                3'b000: alu_result = alu_arith_bit ? alu_src_a - alu_src_b
                                                   : alu_src_a + alu_src_b;
                3'b001: begin
                    if (alu_src_b[4:0] <= 5'd3) begin
                        alu_result = alu_src_a << alu_src_b[4:0];
                    end else begin
                        alu_result = alu_src_a << 3;
                        alu_shamt  = alu_src_b[4:0] - 5'd3;
                        alu_ready  = 1'b0;
                    end
                end
                3'b010: alu_result = {31'b0, $signed(alu_src_a) < $signed(alu_src_b)};
                3'b011: alu_result = {31'b0, alu_src_a < alu_src_b};
                3'b100: alu_result = alu_src_a ^ alu_src_b;
                3'b101: begin
                    if (alu_src_b[4:0] == 5'd0) begin
                        alu_result = alu_src_a;
                    end else begin
                        m_step = (alu_src_b[4:0] > 5'd3) ? 5'd3 : alu_src_b[4:0];
                        if (alu_arith_bit) alu_result = $signed(alu_src_a) >>> m_step;
                        else               alu_result = alu_src_a >> m_step;
                        alu_shamt = alu_src_b[4:0] - m_step;
                        alu_ready = 1'b0;
                    end
                end
                3'b110:  alu_result = alu_src_a | alu_src_b;
                default: alu_result = alu_src_a & alu_src_b;
            endcase
        end
    end

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        taken;
        logic        illegal;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got data 0x%08h, expected no response", rsp_data);
            end else begin
                e = exp_q.pop_front();
                check({e.tag, "_data"}, rsp_data, e.data);
                check({e.tag, "_taken"}, 32'(rsp_taken), 32'(e.taken));
                check({e.tag, "_illegal"}, 32'(rsp_illegal), 32'(e.illegal));
            end
        end
    end

    function automatic logic [31:0] mk_r(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction
    function automatic logic [31:0] mk_i(input logic [11:0] imm, input logic [2:0] f3);
        return {imm, 5'd1, f3, 5'd3, 7'b0010011};
    endfunction
    function automatic logic [31:0] mk_b(input logic [2:0] f3);
        return {7'd0, 5'd2, 5'd1, f3, 5'd0, 7'b1100011};
    endfunction

    logic [4:0] seq_b [0:15];
    int         lat, starts, shadd_cyc, arith_first;

    // Issue one request; latency counted in cycles from the accept edge to rsp_valid.
    task automatic run_op(input string tag, input logic [31:0] instr, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic [31:0] edata, input logic etaken,
                          input logic eillegal, input int elat, input int hold);
        exp_t        e;
        logic [31:0] snap_data;
        logic        snap_ill, snap_tk;
        e.tag = tag; e.data = edata; e.taken = etaken; e.illegal = eillegal;
        exp_q.push_back(e);
        rsp_ready = (hold == 0);
        req_instr = instr; req_rs1 = rs1; req_rs2 = rs2; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0; starts = 0; shadd_cyc = 0; arith_first = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
            if (lat <= 16) seq_b[lat-1] = alu_src_b[4:0];
            starts    += int'(alu_start);
            shadd_cyc += int'(alu_shadd);
            if (lat == 1) arith_first = int'(alu_arith_bit);
        end
        check({tag, "_latency"}, lat, elat);
        check({tag, "_starts"}, starts, eillegal ? 0 : 1);
        if (hold > 0) begin
            snap_data = rsp_data; snap_ill = rsp_illegal; snap_tk = rsp_taken;
            repeat (hold) begin
                @(negedge clk);
                check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
                check({tag, "_hold_data"}, rsp_data, snap_data);
                check({tag, "_hold_flags"}, {30'd0, rsp_illegal, rsp_taken},
                      {30'd0, snap_ill, snap_tk});
            end
            @(posedge clk); #1;
            rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        check({tag, "_back_idle"}, 32'(req_ready), 32'd1);
    endtask

    int vcount;

    initial begin
        rst_n = 1'b1; req_valid = 1'b0; req_instr = 32'd0; req_rs1 = 32'd0; req_rs2 = 32'd0;
        rsp_ready = 1'b1; flush = 1'b0;
        #1 rst_n = 1'b0;
        #10;
        check("rst_ctrl", {23'd0, req_ready, rsp_valid, rsp_taken, rsp_illegal, alu_start,
                           alu_arith_bit, alu_shadd, alu_branch, alu_f3 != 3'd0}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_src_a", alu_src_a, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        #1 check("rst_release_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;

        run_op("add", mk_r(7'b0000000, 3'b000), 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 2, 0);
        run_op("sub", mk_r(7'b0100000, 3'b000), 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 2, 0);
        check("sub_arith", arith_first, 1);
        run_op("slli31", mk_i(12'h01F, 3'b001), 32'd1, 32'd0, 32'h8000_0000, 1'b0, 1'b0, 12, 0);
        for (int k = 0; k < 11; k++) check("slli31_src_b", 32'(seq_b[k]), 32'(31 - 3 * k));
        run_op("srai4", mk_i(12'h404, 3'b101), 32'h8000_0000, 32'd0, 32'hF800_0000,
               1'b0, 1'b0, 4, 0);
        check("srai4_arith", arith_first, 1);
        run_op("addi400", mk_i(12'h400, 3'b000), 32'd1, 32'd0, 32'h0000_0401, 1'b0, 1'b0, 2, 0);
        check("addi400_arith", arith_first, 0);
        run_op("addi_neg", mk_i(12'hFFF, 3'b000), 32'd5, 32'd0, 32'd4, 1'b0, 1'b0, 2, 0);
        run_op("sra8", mk_r(7'b0100000, 3'b101), 32'hFFFF_0000, 32'd8, 32'hFFFF_FF00,
               1'b0, 1'b0, 5, 0);
        run_op("srl1", mk_r(7'b0000000, 3'b101), 32'h8000_0000, 32'd1, 32'h4000_0000,
               1'b0, 1'b0, 3, 0);
        run_op("sh2add", mk_r(7'b0010000, 3'b100), 32'd3, 32'd10, 32'd22, 1'b0, 1'b0, 3, 0);
        check("sh2add_shadd_cycles", shadd_cyc, 2);
        run_op("beq", mk_b(3'b000), 32'd9, 32'd9, 32'd1, 1'b1, 1'b0, 2, 0);
        run_op("bne", mk_b(3'b001), 32'd9, 32'd9, 32'd0, 1'b0, 1'b0, 2, 0);
        run_op("blt", mk_b(3'b100), 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b1, 1'b0, 2, 0);
        run_op("ill_opc", 32'h0000_0000, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1, 1, 5);
        run_op("ill_f7", mk_r(7'b0000001, 3'b000), 32'd5, 32'd7, 32'd0, 1'b0, 1'b1, 1, 0);
        run_op("ill_br", mk_b(3'b010), 32'd5, 32'd7, 32'd0, 1'b0, 1'b1, 1, 0);
        run_op("ill_sub_f3", mk_r(7'b0100000, 3'b001), 32'd5, 32'd7, 32'd0, 1'b0, 1'b1, 1, 0);
        run_op("ill_shadd_f3", mk_r(7'b0010000, 3'b001), 32'd5, 32'd7, 32'd0, 1'b0, 1'b1, 1, 0);

        // Flush in the third EXEC cycle of SLL by 20.
        rsp_ready = 1'b1;
        req_instr = mk_r(7'b0000000, 3'b001); req_rs1 = 32'd1; req_rs2 = 32'd20;
        req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 flush = 1'b1;
        @(negedge clk);
        check("flush_in_exec3", alu_src_b, 32'd14);
        @(posedge clk); #1 flush = 1'b0;
        check("flush_idle", {28'd0, req_ready, rsp_valid, alu_start, alu_src_a != 32'd0},
              32'h8);
        vcount = 0;
        repeat (12) begin
            @(negedge clk);
            vcount += int'(rsp_valid);
        end
        check("flush_no_rsp", vcount, 0);

        // Asynchronous reset in the third EXEC cycle of SLLI by 31.
        @(posedge clk); #1;
        req_instr = mk_i(12'h01F, 3'b001); req_rs1 = 32'd1; req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_mid_in_exec", 32'(alu_src_b[4:0]), 32'd25);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ctrl", {23'd0, req_ready, rsp_valid, rsp_taken, rsp_illegal, alu_start,
                               alu_arith_bit, alu_shadd, alu_branch, alu_f3 != 3'd0}, 32'd0);
        check("rst_mid_src_a", alu_src_a, 32'd0);
        check("rst_mid_src_b", alu_src_b, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        vcount = 0;
        repeat (15) begin
            @(negedge clk);
            vcount += int'(rsp_valid);
        end
        check("rst_mid_no_rsp", vcount, 0);
        check("rst_mid_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;

        run_op("add_after_rst", mk_r(7'b0000000, 3'b000), 32'd100, 32'd23, 32'd123,
               1'b0, 1'b0, 2, 0);
        check("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
